branch_predictor_gshare: RTL and testbench
==========================================

// Module: branch_predictor_gshare
// PURPOSE
//  Parametrised 2^IDX_W-entry table of CTR_W-bit saturating counters, with a speculative global history register (GHR).
//  MODE selects bimodal or gshare indexing.
//  Sits between the instruction queue (predict port, combinational lookup) and the ROB (commit-time update and GHR repair).
//  Keeps a committed-branch / mispredict statistics counter pair for performance debug.
// PARAMETERS
//  IDX_W   8  table index width; table depth = 2**IDX_W
//  CTR_W   2  counter width (>=1); predict taken when counter MSB = 1
//  GHR_W   8  global history length; must satisfy 1 <= GHR_W <= IDX_W
//  MODE    1  0 = bimodal (index = pc_idx), 1 = gshare (index = pc_idx ^ zero-extended GHR)
//  INIT    1  counter reset value (must be < 2**CTR_W); default = weakly not-taken for CTR_W=2
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous active-high reset
//  rdy            in   1      global ready; 0 freezes all state
//  pred_valid     in   1      a conditional branch is being enqueued this cycle
//  pred_pc_idx    in   IDX_W  PC-derived index of the branch being predicted
//  pred_taken     out  1      prediction (combinational from current table/GHR)
//  pred_ghr       out  GHR_W  GHR snapshot before this prediction's shift; travels with the branch to the ROB
//  upd_valid      in   1      ROB commits a conditional branch this cycle
//  upd_pc_idx     in   IDX_W  index of the committing branch
//  upd_ghr        in   GHR_W  that branch's pred_ghr snapshot
//  upd_taken      in   1      resolved direction
//  upd_mispredict in   1      resolved direction differs from prediction; qualified by upd_valid
//  stat_commit    out  32     committed conditional branches (wraps modulo 2**32)
//  stat_mispred   out  32     committed mispredicts (wraps modulo 2**32)
// BEHAVIOUR
//  - Reset (rst=1, has priority over rdy): every counter = INIT, GHR = 0, both stats = 0.
//    Post-reset outputs: pred_ghr = 0, pred_taken = INIT[CTR_W-1].
//  - rdy=0 and rst=0: table, GHR and stats hold. Predict outputs stay combinationally valid.
//  - Lookup, zero latency:
//    - ridx = MODE ? pred_pc_idx ^ {0,GHR} : pred_pc_idx.
//    - pred_taken = table[ridx][CTR_W-1].
//    - pred_ghr = GHR.
//  - Update index: widx = MODE ? upd_pc_idx ^ {0,upd_ghr} : upd_pc_idx. Uses the snapshot, never the live GHR.
//  - Counter update on upd_valid, taking effect next edge:
//    - upd_taken=1: increment, saturating at 2**CTR_W-1.
//    - upd_taken=0: decrement, saturating at 0.
//    - The counter is trained on every commit, not only on mispredicts.
//  - GHR next-state, in priority order:
//    1. upd_valid & upd_mispredict -> GHR = {upd_ghr[GHR_W-2:0], upd_taken} (repair); any same-cycle pred_valid is discarded, since the ROB flushes it.
//    2. pred_valid -> GHR = {GHR[GHR_W-2:0], pred_taken} (speculative shift).
//    3. else hold. For GHR_W=1, the shift result is just the new bit.
//  - Same-entry read/write in one cycle (ridx == widx): pred_taken returns the OLD counter (no bypass). The new value is visible from the next cycle.
//  - Correct-prediction commit (upd_mispredict=0) never touches GHR.
//  - Stats on upd_valid: stat_commit += 1; if upd_mispredict, also stat_mispred += 1.
//  - Counter update and GHR repair/shift are independent and may occur in the same cycle.
//  - Reset asserted mid-stream wins over any same-cycle update or predict.
// TESTING (IDX_W=4, CTR_W=2, GHR_W=4, INIT=1 unless stated)
//  1. Reset: pulse rst, sweep pred_pc_idx 0..15 -> pred_taken=0, pred_ghr=4'h0; stats = 0.
//  2. MODE=0 saturation, idx 5:
//     - 3x upd_taken=1 -> counter 2,3,3; pred_taken=1 from the cycle after the 1st update.
//     - Then 4x upd_taken=0 -> 2,1,0,0; pred_taken=0 from the cycle after the 2nd.
//  3. MODE=1 GHR:
//     - Preload table so idx 3^GHR predicts taken; 3 pred_valid -> GHR 0001, 0011, 0111.
//     - Then upd_valid, upd_mispredict=1, upd_ghr=0001, upd_taken=0 with pred_valid=1 same cycle -> GHR=0010; stat_mispred=1.
//  4. Same-entry collision: counter[7]=1, pred_pc_idx=7 and upd_valid/upd_pc_idx=7/upd_taken=1 same cycle -> pred_taken=0 that cycle, 1 next cycle.
//  5. rdy=0 for 5 cycles with pred_valid=1, upd_valid=1 -> GHR, counters, stats unchanged. rst=1 while rdy=0 -> full reset.
//  6. Stats wrap: force stat_commit=32'hFFFF_FFFF, one commit -> 0.

Source files
------------

// File: rtl/branch_predictor_gshare_if.sv
// Predict and commit-update signal bundle between the instruction queue / ROB side and the predictor.
// Predict side: pred_taken/pred_ghr are valid whenever pred_pc_idx is; pred_valid commits the GHR shift. Update side: upd_valid qualifies all upd_* fields; there is no backpressure.
interface branch_predictor_gshare_if #(
  parameter int IDX_W = 8,
  parameter int GHR_W = 8
);
  logic             pred_valid;
  logic [IDX_W-1:0] pred_pc_idx;
  logic             pred_taken;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_pc_idx;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_taken;
  logic             upd_mispredict;
  logic [31:0]      stat_commit;
  logic [31:0]      stat_mispred;

  modport master (
    output pred_valid, pred_pc_idx, upd_valid, upd_pc_idx, upd_ghr, upd_taken, upd_mispredict,
    input  pred_taken, pred_ghr, stat_commit, stat_mispred
  );

  modport slave (
    input  pred_valid, pred_pc_idx, upd_valid, upd_pc_idx, upd_ghr, upd_taken, upd_mispredict,
    output pred_taken, pred_ghr, stat_commit, stat_mispred
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Bimodal/gshare direction predictor: saturating-counter table, speculative GHR with
// commit-time repair, and commit/mispredict statistics.
module branch_predictor_gshare #(
  parameter int IDX_W = 8,
  parameter int CTR_W = 2,
  parameter int GHR_W = 8,
  parameter int MODE  = 1,
  parameter int INIT  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  branch_predictor_gshare_if.slave bp
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [CTR_W-1:0] table_q [DEPTH];
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [31:0]      stat_commit_q, stat_commit_d;
  logic [31:0]      stat_mispred_q, stat_mispred_d;
  logic [IDX_W-1:0] ridx, widx;
  logic [CTR_W-1:0] ctr_old, ctr_new;
  logic [GHR_W-1:0] ghr_shift, ghr_repair;

  assign ridx = (MODE != 0) ? (bp.pred_pc_idx ^ IDX_W'(ghr_q))      : bp.pred_pc_idx;
  assign widx = (MODE != 0) ? (bp.upd_pc_idx  ^ IDX_W'(bp.upd_ghr)) : bp.upd_pc_idx;

  // Table read is the registered value, so a same-cycle write to ridx is not bypassed.
  assign bp.pred_taken   = table_q[ridx][CTR_W-1];
  assign bp.pred_ghr     = ghr_q;
  assign bp.stat_commit  = stat_commit_q;
  assign bp.stat_mispred = stat_mispred_q;

  generate
    if (GHR_W == 1) begin : g_ghr1
      assign ghr_shift  = bp.pred_taken;
      assign ghr_repair = bp.upd_taken;
    end else begin : g_ghrn
      assign ghr_shift  = {ghr_q[GHR_W-2:0], bp.pred_taken};
      assign ghr_repair = {bp.upd_ghr[GHR_W-2:0], bp.upd_taken};
    end
  endgenerate

  assign ctr_old = table_q[widx];

  always_comb begin
    ctr_new = ctr_old;
    if (bp.upd_taken) begin
      if (ctr_old != CTR_MAX) ctr_new = ctr_old + 1'b1;
    end else begin
      if (ctr_old != '0) ctr_new = ctr_old - 1'b1;
    end
  end

  // A mispredict repair discards any same-cycle speculative shift: the ROB flushes that branch.
  always_comb begin
    ghr_d = ghr_q;
    if (bp.upd_valid && bp.upd_mispredict) ghr_d = ghr_repair;
    else if (bp.pred_valid)                ghr_d = ghr_shift;
  end

  always_comb begin
    stat_commit_d  = stat_commit_q;
    stat_mispred_d = stat_mispred_q;
    if (bp.upd_valid) begin
      stat_commit_d = stat_commit_q + 32'd1;
      if (bp.upd_mispredict) stat_mispred_d = stat_mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_W'(INIT);
    end else if (rdy && bp.upd_valid) begin
      table_q[widx] <= ctr_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q          <= '0;
      stat_commit_q  <= '0;
      stat_mispred_q <= '0;
    end else if (rdy) begin
      ghr_q          <= ghr_d;
      stat_commit_q  <= stat_commit_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: one bimodal (MODE=0) and one gshare (MODE=1) instance, IDX_W=4, CTR_W=2, GHR_W=4, INIT=1.
module tb_branch_predictor_gshare;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic upd_taken;
    logic exp_taken;
  } vec_t;

  vec_t sat_vec [7];

  branch_predictor_gshare_if #(.IDX_W(4), .GHR_W(4)) bp0 ();
  branch_predictor_gshare_if #(.IDX_W(4), .GHR_W(4)) bp1 ();

  branch_predictor_gshare #(.IDX_W(4), .CTR_W(2), .GHR_W(4), .MODE(0), .INIT(1)) dut0 (
    .clk(clk), .rst(rst), .rdy(rdy), .bp(bp0.slave)
  );
  branch_predictor_gshare #(.IDX_W(4), .CTR_W(2), .GHR_W(4), .MODE(1), .INIT(1)) dut1 (
    .clk(clk), .rst(rst), .rdy(rdy), .bp(bp1.slave)
  );

  always #5 clk = ~clk;

  // Clock / drive helpers: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp0.pred_valid = 0; bp0.pred_pc_idx = 0; bp0.upd_valid = 0; bp0.upd_pc_idx = 0;
    bp0.upd_ghr = 0; bp0.upd_taken = 0; bp0.upd_mispredict = 0;
    bp1.pred_valid = 0; bp1.pred_pc_idx = 0; bp1.upd_valid = 0; bp1.upd_pc_idx = 0;
    bp1.upd_ghr = 0; bp1.upd_taken = 0; bp1.upd_mispredict = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic upd1(input logic [3:0] idx, input logic [3:0] ghr, input logic tk, input logic mp);
    bp1.upd_valid = 1; bp1.upd_pc_idx = idx; bp1.upd_ghr = ghr;
    bp1.upd_taken = tk; bp1.upd_mispredict = mp;
  endtask

  initial begin
    sat_vec[0] = '{1'b1, 1'b1};  // 1->2
    sat_vec[1] = '{1'b1, 1'b1};  // 2->3
    sat_vec[2] = '{1'b1, 1'b1};  // 3->3
    sat_vec[3] = '{1'b0, 1'b1};  // 3->2
    sat_vec[4] = '{1'b0, 1'b0};  // 2->1
    sat_vec[5] = '{1'b0, 1'b0};  // 1->0
    sat_vec[6] = '{1'b0, 1'b0};  // 0->0

    idle();
    rst = 1; rdy = 1;
    tick(); tick();
    rst = 0;

    // Reset sweep
    for (int i = 0; i < 16; i++) begin
      bp0.pred_pc_idx = 4'(i); bp1.pred_pc_idx = 4'(i);
      #1;
      check($sformatf("rst_taken0_%0d", i), 32'(bp0.pred_taken), 32'd0);
      check($sformatf("rst_taken1_%0d", i), 32'(bp1.pred_taken), 32'd0);
    end
    check("rst_ghr0", 32'(bp0.pred_ghr), 32'd0);
    check("rst_ghr1", 32'(bp1.pred_ghr), 32'd0);
    check("rst_commit", bp0.stat_commit, 32'd0);
    check("rst_mispred", bp1.stat_mispred, 32'd0);
    idle();

    // Saturation on bimodal idx 5
    for (int i = 0; i < 7; i++) begin
      bp0.upd_valid = 1; bp0.upd_pc_idx = 4'd5; bp0.upd_taken = sat_vec[i].upd_taken;
      tick();
      idle();
      bp0.pred_pc_idx = 4'd5;
      #1;
      check($sformatf("sat_%0d", i), 32'(bp0.pred_taken), 32'(sat_vec[i].exp_taken));
    end
    check("sat_ghr_hold", 32'(bp0.pred_ghr), 32'd0);

    // Same-entry collision: no bypass
    bp0.pred_pc_idx = 4'd7; bp0.upd_valid = 1; bp0.upd_pc_idx = 4'd7; bp0.upd_taken = 1;
    #1;
    check("coll_same_cycle", 32'(bp0.pred_taken), 32'd0);
    tick();
    idle();
    bp0.pred_pc_idx = 4'd7;
    #1;
    check("coll_next_cycle", 32'(bp0.pred_taken), 32'd1);
    check("stat_commit0", bp0.stat_commit, 32'd8);
    check("stat_mispred0", bp0.stat_mispred, 32'd0);
    idle();

    // gshare: preload entries 3, 2, 0 to weakly taken (correct commits leave GHR alone)
    upd1(4'd3, 4'd0, 1'b1, 1'b0); tick();
    upd1(4'd2, 4'd0, 1'b1, 1'b0); tick();
    upd1(4'd0, 4'd0, 1'b1, 1'b0); tick();
    idle();
    #1;
    check("preload_ghr", 32'(bp1.pred_ghr), 32'd0);
    bp1.pred_valid = 1; bp1.pred_pc_idx = 4'd3;
    #1; check("spec_taken_a", 32'(bp1.pred_taken), 32'd1);
    tick(); check("spec_ghr_a", 32'(bp1.pred_ghr), 32'h1);
    #1; check("spec_taken_b", 32'(bp1.pred_taken), 32'd1);
    tick(); check("spec_ghr_b", 32'(bp1.pred_ghr), 32'h3);
    #1; check("spec_taken_c", 32'(bp1.pred_taken), 32'd1);
    tick(); check("spec_ghr_c", 32'(bp1.pred_ghr), 32'h7);
    // Repair wins over same-cycle predict
    upd1(4'd3, 4'h1, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    check("repair_ghr", 32'(bp1.pred_ghr), 32'h2);
    check("repair_mispred", bp1.stat_mispred, 32'd1);
    check("repair_commit", bp1.stat_commit, 32'd4);
    // Entry 3^1=2 was decremented from 2 to 1 by the repair commit
    bp1.pred_pc_idx = 4'd0;  // ridx = 0 ^ 2 = 2
    #1;
    check("repair_ctr", 32'(bp1.pred_taken), 32'd0);
    idle();

    // rdy=0 freezes everything
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      bp0.pred_valid = 1; bp0.upd_valid = 1; bp0.upd_pc_idx = 4'd5; bp0.upd_taken = 1;
      bp0.upd_mispredict = 1;
      bp1.pred_valid = 1; bp1.pred_pc_idx = 4'd1;
      upd1(4'd1, 4'd2, 1'b1, 1'b1);
      tick();
    end
    idle();
    #1;
    check("frz_ghr1", 32'(bp1.pred_ghr), 32'h2);
    check("frz_commit1", bp1.stat_commit, 32'd4);
    check("frz_mispred1", bp1.stat_mispred, 32'd1);
    check("frz_ghr0", 32'(bp0.pred_ghr), 32'h0);
    check("frz_commit0", bp0.stat_commit, 32'd8);
    bp0.pred_pc_idx = 4'd5;
    bp1.pred_pc_idx = 4'd1;  // ridx = 1 ^ 2 = 3, still weakly taken
    #1;
    check("frz_ctr0", 32'(bp0.pred_taken), 32'd0);
    check("frz_ctr1", 32'(bp1.pred_taken), 32'd1);
    // Reset while frozen
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("frz_rst_ghr1", 32'(bp1.pred_ghr), 32'h0);
    check("frz_rst_commit1", bp1.stat_commit, 32'd0);
    check("frz_rst_mispred1", bp1.stat_mispred, 32'd0);
    check("frz_rst_commit0", bp0.stat_commit, 32'd0);
    bp1.pred_pc_idx = 4'd3;
    #1;
    check("frz_rst_ctr1", 32'(bp1.pred_taken), 32'd0);
    rdy = 1;
    idle();

    // Stats wrap
    force dut0.stat_commit_q = 32'hFFFF_FFFF;
    #1;
    release dut0.stat_commit_q;
    #1;
    check("wrap_pre", bp0.stat_commit, 32'hFFFF_FFFF);
    bp0.upd_valid = 1; bp0.upd_pc_idx = 4'd9; bp0.upd_taken = 0;
    tick();
    idle();
    #1;
    check("wrap_post", bp0.stat_commit, 32'd0);
    check("wrap_mispred", bp0.stat_mispred, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
